// File: rtl/verilog_assign_serializer_pkg.sv
// verilog_assign_ser_pkg
// Shared types and helpers for the assign-path serializer.
//   ser_state_e    : FSM state encoding. PAR keeps its code in every build so
//                    netlists with and without parity line up state-for-state.
//   IDLE_LEVEL_DEF : default serial line level while idle / stop bit.
//   cnt_width()    : bit counter width for a given frame width.
package verilog_assign_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } ser_state_e;

  localparam logic IDLE_LEVEL_DEF = 1'b1;

  // $clog2(1) is 0; keep at least one counter bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/verilog_assign_serializer_if.sv
// verilog_assign_serializer_if
// Valid/ready parallel load bus into the serializer.
//   load_valid : producer has a word this cycle
//   load_ready : serializer accepts a word this cycle
//   load_data  : word to transmit, bit 0 first
// Modports: master (producer side), slave (serializer side).
interface verilog_assign_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/verilog_assign_serializer_shift.sv
// verilog_assign_ser_shift
// WIDTH-bit load/shift register for the serializer data path.
//   clk, rst   : clock, synchronous active-high reset
//   i_capture  : load i_data (has priority over shift)
//   i_shift_en : shift right by one, zero fill from the top
//   i_data     : parallel word
//   o_lsb      : current bit 0, the next bit to go on the line
module verilog_assign_ser_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_capture,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_lsb
);

  logic [WIDTH-1:0] r_sr;
  wire              w_lsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_capture) begin
      r_sr <= i_data;
    end else if (i_shift_en) begin
      r_sr <= {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  assign w_lsb = r_sr[0];
  assign o_lsb = w_lsb;

endmodule

// File: rtl/verilog_assign_serializer.sv
// verilog_assign_serializer
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB
// first, optional even-parity bit, stop bit. Every output is carried to its
// port by a continuous assign from an internal net.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load_if      : valid/ready load bus (slave modport)
//   ser_out      : serial line, assigned from the internal net of r_ser_q
//   ser_out_copy : alias of ser_out
//   busy         : frame in progress (state != IDLE)
//   frame_done   : one-cycle pulse during the stop-bit cycle
//   parity_out   : internal parity register (parity builds only)
// Build option: define VERILOG_ASSIGN_SER_PARITY_EN to add the parity bit,
// the PAR state and the parity_out port.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | line idle, load_ready high, waiting for a load
// ST_START | start bit (!IDLE_LEVEL) on the line
// ST_SHIFT | WIDTH data bits, counter runs 0..WIDTH-1
// ST_PAR   | even-parity bit on the line (parity builds)
// ST_STOP  | stop bit (IDLE_LEVEL), frame_done high
module verilog_assign_serializer
  import verilog_assign_ser_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  verilog_assign_serializer_if.slave  load_if,
  output logic                        ser_out,
  output logic                        ser_out_copy,
  output logic                        busy,
  output logic                        frame_done
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
  ,
  output logic                        parity_out
`endif
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ser_q;
  logic             r_frame_done;
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
  logic             r_parity;
`endif

  wire w_idle;
  wire w_ready;
  wire w_xfer;
  wire w_shift_en;
  wire w_lsb;
  wire w_ser_q;

  assign w_idle     = (r_state == ST_IDLE);
  // Ready depends only on state and reset so no valid->ready loop can form.
  assign w_ready    = w_idle && !rst;
  assign w_xfer     = w_ready && load_if.load_valid;
  // Shifting in START exposes bit 1 at the first SHIFT edge; the extra
  // shift on the last SHIFT cycle only moves zeros and is harmless.
  assign w_shift_en = (r_state == ST_START) || (r_state == ST_SHIFT);

  verilog_assign_ser_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_capture  (w_xfer),
    .i_shift_en (w_shift_en),
    .i_data     (load_if.load_data),
    .o_lsb      (w_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ser_q      <= IDLE_LEVEL;
      r_frame_done <= 1'b0;
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt   <= '0;
          r_ser_q <= IDLE_LEVEL;
          if (w_xfer) begin
            r_state <= ST_START;
            r_ser_q <= ~IDLE_LEVEL;
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
            r_parity <= ^load_if.load_data;
`endif
          end
        end
        ST_START: begin
          r_state <= ST_SHIFT;
          r_cnt   <= '0;
          r_ser_q <= w_lsb;
        end
        ST_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
            r_state <= ST_PAR;
            r_ser_q <= r_parity;
`else
            r_state      <= ST_STOP;
            r_ser_q      <= IDLE_LEVEL;
            r_frame_done <= 1'b1;
`endif
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_ser_q <= w_lsb;
          end
        end
        ST_PAR: begin
          r_state      <= ST_STOP;
          r_ser_q      <= IDLE_LEVEL;
          r_frame_done <= 1'b1;
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
          r_ser_q <= IDLE_LEVEL;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ser_q <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign w_ser_q            = r_ser_q;
  assign ser_out            = w_ser_q;
  assign ser_out_copy       = ser_out;
  assign busy               = !w_idle;
  assign frame_done         = r_frame_done;
  assign load_if.load_ready = w_ready;
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
  assign parity_out         = r_parity;
`endif

endmodule

// File: tb/tb_verilog_assign_serializer.sv
module tb_verilog_assign_serializer;

`ifdef VERILOG_ASSIGN_SER_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FL8 = 8 + 2 + PAR_EN;
  localparam int FL2 = 2 + 2 + PAR_EN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  verilog_assign_serializer_if #(.WIDTH(8)) bus8 ();
  verilog_assign_serializer_if #(.WIDTH(2)) bus2 ();

  logic ser8, copy8, busy8, done8;
  logic ser2, copy2, busy2, done2;
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
  logic par8, par2;
`endif

  verilog_assign_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .load_if      (bus8),
    .ser_out      (ser8),
    .ser_out_copy (copy8),
    .busy         (busy8),
    .frame_done   (done8)
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
    ,
    .parity_out   (par8)
`endif
  );

  verilog_assign_serializer #(.WIDTH(2), .IDLE_LEVEL(1'b1)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .load_if      (bus2),
    .ser_out      (ser2),
    .ser_out_copy (copy2),
    .busy         (busy2),
    .frame_done   (done2)
`ifdef VERILOG_ASSIGN_SER_PARITY_EN
    ,
    .parity_out   (par2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the transfer cycle (k = 1 is start).
  function automatic logic exp_bit(input logic [15:0] d, input int w, input int k);
    logic p;
    p = 1'b0;
    if (k == 1) return 1'b0;
    if (k <= w + 1) return d[k-2];
    if (PAR_EN != 0 && k == w + 2) begin
      for (int i = 0; i < w; i++) p = p ^ d[i];
      return p;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] d);
    bus8.load_valid = 1'b1;
    bus8.load_data  = d;
    chk("start_ready", 32'(bus8.load_ready), 32'd1);
  endtask

  // Walks one WIDTH=8 frame from N+1 to N+FL8, then checks N+FL8+1.
  task automatic check_frame8(input logic [7:0] d, input string tag,
                              input logic keep_valid, input logic [7:0] next_d);
    for (int k = 1; k <= FL8; k++) begin
      tick();
      if (k == 1) begin
        bus8.load_valid = keep_valid;
        bus8.load_data  = next_d;
      end
      chk({tag, "_ser"},   32'(ser8),  32'(exp_bit(16'(d), 8, k)));
      chk({tag, "_copy"},  32'(copy8), 32'(exp_bit(16'(d), 8, k)));
      chk({tag, "_done"},  32'(done8), 32'(k == FL8));
      chk({tag, "_busy"},  32'(busy8), 32'd1);
      chk({tag, "_ready"}, 32'(bus8.load_ready), 32'd0);
    end
    tick();
    chk({tag, "_end_ready"}, 32'(bus8.load_ready), 32'd1);
    chk({tag, "_end_busy"},  32'(busy8), 32'd0);
    chk({tag, "_end_done"},  32'(done8), 32'd0);
  endtask

  logic [1:0] d2_vals [2];

  initial begin
    d2_vals[0] = 2'b10;
    d2_vals[1] = 2'b01;
    bus8.load_valid = 1'b0;
    bus8.load_data  = '0;
    bus2.load_valid = 1'b0;
    bus2.load_data  = '0;

    rst = 1'b1;
    repeat (2) tick();
    chk("rst_ser",   32'(ser8),  32'd1);
    chk("rst_busy",  32'(busy8), 32'd0);
    chk("rst_done",  32'(done8), 32'd0);
    chk("rst_ready", 32'(bus8.load_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus8.load_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ser",    32'(ser8),  32'd1);
      chk("idle_copy",   32'(copy8), 32'd1);
      chk("idle_ready",  32'(bus8.load_ready), 32'd1);
      chk("idle_busy",   32'(busy8), 32'd0);
      chk("idle_done",   32'(done8), 32'd0);
      chk("idle2_ser",   32'(ser2),  32'd1);
      chk("idle2_ready", 32'(bus2.load_ready), 32'd1);
    end

    // 0xA5: 0,1,0,1,0,0,1,0,1,[par],1
    start8(8'hA5);
    check_frame8(8'hA5, "a5", 1'b0, 8'h00);

    // valid held high: 0x3C then 0xFF accepted only once IDLE returns
    start8(8'h3C);
    check_frame8(8'h3C, "b2b_3c", 1'b1, 8'hFF);
    check_frame8(8'hFF, "b2b_ff", 1'b0, 8'h00);

    start8(8'h01);
    check_frame8(8'h01, "x01", 1'b0, 8'h00);

    // reset during bit 3 of an 0xA5 frame
    start8(8'hA5);
    tick();
    bus8.load_valid = 1'b0;
    chk("abort_start", 32'(ser8), 32'd0);
    repeat (4) tick();
    chk("abort_n5_ser", 32'(ser8), 32'd0);
    chk("abort_n5_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", 32'(bus8.load_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_n6_ser",   32'(ser8),  32'd1);
    chk("abort_n6_busy",  32'(busy8), 32'd0);
    chk("abort_n6_ready", 32'(bus8.load_ready), 32'd1);
    chk("abort_n6_done",  32'(done8), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_quiet_done", 32'(done8), 32'd0);
      chk("abort_quiet_ser",  32'(ser8),  32'd1);
    end

    // WIDTH=2: 2'b10 -> 0,0,1,[par],1 ; then 2'b01 -> 0,1,0,[par],1
    for (int f = 0; f < 2; f++) begin
      bus2.load_valid = 1'b1;
      bus2.load_data  = d2_vals[f];
      chk("w2_ready", 32'(bus2.load_ready), 32'd1);
      for (int k = 1; k <= FL2; k++) begin
        tick();
        if (k == 1) bus2.load_valid = 1'b0;
        chk("w2_ser",  32'(ser2),  32'(exp_bit(16'(d2_vals[f]), 2, k)));
        chk("w2_copy", 32'(copy2), 32'(exp_bit(16'(d2_vals[f]), 2, k)));
        chk("w2_done", 32'(done2), 32'(k == FL2));
        chk("w2_busy", 32'(busy2), 32'd1);
      end
      tick();
      chk("w2_end_ready", 32'(bus2.load_ready), 32'd1);
      chk("w2_end_busy",  32'(busy2), 32'd0);
      chk("w2_end_ser",   32'(ser2),  32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
